booth_r4_seq_mult: RTL
======================

Name: booth_r4_seq_mult

Overview:
- Parametrised, iterative radix-4 Booth signed multiplier with valid/ready handshakes on input and output.
- A per-transaction mode selects exact Booth recoding or the approximate recoder, plus optional forcing of a product bit band to 1 (hybrid approximation).
- Processes one Booth digit per clock, so an N-bit multiply takes N/2 cycles.
- Sits between operand producers and accumulators in the approximate-arithmetic datapath.

Parameters:
- N, 16, operand width in bits; even, >=4.
- APX_LO, 2, lowest product bit of the forced band.
- APX_W, 6, width of the forced band; APX_LO+APX_W <= 2N; APX_W=0 disables forcing.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- x  input  N  multiplicand, two's complement.
- y  input  N  multiplier, two's complement.
- mode  input  2  bit0 = approximate recoder; bit1 = force band to 1.
- out_valid  output  1  p holds a finished product.
- out_ready  input  1  consumer accepts p.
- p  output  2N  product, two's complement.
- busy  output  1  high in CALC.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state IDLE; in_ready=1, out_valid=0, busy=0, p=0; accumulator and digit counter cleared. Reset asserted mid-CALC or in DONE aborts the operation and discards the result.
- FSM IDLE -> CALC -> DONE.
  - in_ready = (IDLE) or (DONE and out_ready).
  - Accept when in_valid && in_ready: x, y and mode are registered, acc=0, cnt=0, state -> CALC.
- CALC: each edge adds digit cnt's partial product and increments cnt.
  - Digit i uses bits {y[2i+1], y[2i], y[2i-1]}, with y[-1]=0.
  - After digit K-1 (K=N/2): p <= final value, out_valid <= 1, state -> DONE.
  - Latency: out_valid rises exactly K edges after the accept edge.
- Exact recoding (mode[0]=0): 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
- Approximate recoding (mode[0]=1): 011 -> +A; 100 -> -A; all other codes as exact.
- Arithmetic:
  - A is x sign-extended to N+2 bits; -A is its two's complement at N+2 bits, so x=-2^(N-1) is handled correctly.
  - Each partial product is sign-extended to 2N bits and shifted left 2i.
  - The sum wraps modulo 2^(2N).
- Forcing (mode[1]=1): when loading p, bits [APX_LO+APX_W-1 : APX_LO] are set to 1; other bits are unchanged. Not applied when APX_W=0.
- DONE: p and out_valid are held stable while out_ready=0.
  - On out_ready=1: out_valid drops next edge unless a new accept occurs on the same edge. In that case state -> CALC and out_valid -> 0.
  - p keeps the last result until the next completion.
- in_valid during CALC is ignored (in_ready=0); operand changes during CALC do not affect the result.
- mode is sampled only at accept.

Test Plan:
- Exact, N=16, mode=00: x=3, y=5 -> out_valid exactly 8 cycles after accept, p=0x0000000F. x=0x7FFF, y=0x7FFF -> 0x3FFF0001. x=0x8000, y=0x8000 -> 0x40000000. x=-7 (0xFFF9), y=9 -> 0xFFFFFFC1.
- Approximate recoder, mode=01: x=5, y=2 -> digit0 code 100 maps to -A, so p=0x0000000F (exact result is 10). Repeat with mode=00 -> 0x0000000A.
- Forcing, mode=10: x=100, y=100 -> 0x000027FC. Mode=11, x=5, y=2 -> 0x000000FF.
- Backpressure: complete x=3, y=5, hold out_ready=0 for 5 cycles while in_valid=1 with x=2, y=2.
  - Required: p stays 0x0F, in_ready=0 throughout.
  - Raise out_ready: same-edge accept of the new operands, out_valid drops.
  - Next result 0x4 arrives 8 cycles later.
- Reset mid-operation: assert rst_n=0 at cycle 4 of CALC -> immediately out_valid=0, p=0, busy=0, in_ready=1. A fresh x=6, y=7 then yields 0x2A after 8 cycles.
- Operand change during CALC: accept x=11, y=13, then drive x=0, y=0 with in_valid=1 during CALC -> p=0x0000008F, second request accepted only after the handshake.

Source files
------------

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier, one digit per clock, with valid/ready
// handshakes, a per-transaction approximate recoder and optional forcing of a product bit band.
module booth_r4_seq_mult #(
    parameter int N      = 16,
    parameter int APX_LO = 2,
    parameter int APX_W  = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);
    localparam int K  = N / 2;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [2*N-1:0] BAND_MASK =
        (APX_W == 0) ? '0 : (({(2*N){1'b1}} >> (2*N - APX_W)) << APX_LO);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d, y_q, y_d;
    logic [1:0]     mode_q, mode_d;
    logic [2*N-1:0] acc_q, acc_d, p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic [N:0]     y_ext;
    logic [2:0]     code;
    logic [N+1:0]   a_ext, a2, neg_a, neg_a2, pp;
    logic [2*N-1:0] pp_shift, sum;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign busy      = (state_q == CALC);

    // y[-1] is the implicit zero below the LSB
    assign y_ext  = {y_q, 1'b0};
    assign a_ext  = {{2{x_q[N-1]}}, x_q};
    assign a2     = {a_ext[N:0], 1'b0};
    assign neg_a  = ~a_ext + 1'b1;
    assign neg_a2 = {neg_a[N:0], 1'b0};

    always_comb begin
        code = 3'b000;
        for (int i = 0; i < K; i++) begin
            if (cnt_q == i[CW-1:0]) code = y_ext[2*i +: 3];
        end
    end

    always_comb begin
        pp = '0;
        case (code)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = mode_q[0] ? a_ext : a2;
            3'b100:         pp = mode_q[0] ? neg_a : neg_a2;
            3'b101, 3'b110: pp = neg_a;
            default:        pp = '0;
        endcase
    end

    assign pp_shift = {{(N-2){pp[N+1]}}, pp} << {cnt_q, 1'b0};
    assign sum      = acc_q + pp_shift;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        case (state_q)
            CALC: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    p_d         = mode_q[1] ? (sum | BAND_MASK) : sum;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase
        // accept is only possible from IDLE or a consumed DONE, so it overrides the case above
        if (accept) begin
            x_d         = x;
            y_d         = y;
            mode_d      = mode;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = CALC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
